// File: rtl/mux_diag_pkg.sv
// Shared types, constants, fan-in cone masks and golden wire model for the mux self-test.
// Pure definitions; no timing or flow control of its own.
package mux_diag_pkg;

  localparam int NUM_WIRES = 9;
  localparam int NUM_VEC   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Entry k: every wire whose fault could make wire k the highest mismatching tap.
  localparam logic [NUM_WIRES-1:0] CONE [NUM_WIRES] = '{
    9'h001, 9'h002, 9'h004, 9'h00C, 9'h014, 9'h034, 9'h04E, 9'h0B5, 9'h1FF
  };

  function automatic logic [NUM_WIRES-1:0] golden(input logic [2:0] v);
    logic i0, i1, s, w6, w7;
    i0 = v[2];
    i1 = v[1];
    s  = v[0];
    w6 = i1 & s;
    w7 = i0 & ~s;
    return {w6 | w7, w7, w6, ~s, s, s, s, i1, i0};
  endfunction

endpackage

// File: rtl/mux_diag_check.sv
// Combinational tap checker: syndrome, mismatch flag and cone mask of the highest syndrome bit.
// Zero latency; no flow control.
module mux_diag_check
  import mux_diag_pkg::*;
(
  input  logic [2:0]           v,
  input  logic [NUM_WIRES-1:0] taps,
  output logic [NUM_WIRES-1:0] syndrome,
  output logic                 mismatch,
  output logic [NUM_WIRES-1:0] cone
);

  always_comb begin
    syndrome = taps ^ golden(v);
    mismatch = |syndrome;
    cone     = CONE[0];
    // Ascending scan so the highest set bit wins.
    for (int k = 0; k < NUM_WIRES; k++) begin
      if (syndrome[k]) cone = CONE[k];
    end
  end

endmodule

// File: rtl/mux_diag_sequencer.sv
// Mux self-test sequencer: 8 vectors x (SETTLE+2) cycles; start is ignored while busy.
// Optional syndrome log build option: MUX_DIAG_SYNDROME_LOG_EN.
module mux_diag_sequencer
  import mux_diag_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_WIRES-1:0] taps,
  output logic                 I0,
  output logic                 I1,
  output logic                 S,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_WIRES-1:0] cand,
  output logic [3:0]           err_cnt,
  output logic                 fault_found
`ifdef MUX_DIAG_SYNDROME_LOG_EN
  ,
  input  logic [2:0]           log_idx,
  output logic [NUM_WIRES-1:0] log_data
`endif
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t               state;
  logic [2:0]           v;
  logic [CW-1:0]        cnt;
  logic [NUM_WIRES-1:0] syndrome;
  logic                 mismatch;
  logic [NUM_WIRES-1:0] cone;
  logic                 run_start;

  assign run_start   = start && (state == ST_IDLE || state == ST_DONE);
  assign fault_found = (err_cnt != 4'd0);

  mux_diag_check u_check (
    .v        (v),
    .taps     (taps),
    .syndrome (syndrome),
    .mismatch (mismatch),
    .cone     (cone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      v       <= '0;
      cnt     <= '0;
      I0      <= 1'b0;
      I1      <= 1'b0;
      S       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cand    <= '1;
      err_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (run_start) begin
            state   <= ST_DRIVE;
            v       <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            cand    <= '1;
            err_cnt <= '0;
          end
        end
        ST_DRIVE: begin
          {I0, I1, S} <= v;
          cnt         <= CW'(SETTLE);
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) begin
            cand    <= cand & cone;
            err_cnt <= err_cnt + 4'd1;
          end
          if (v == 3'd7) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            v     <= v + 3'd1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MUX_DIAG_SYNDROME_LOG_EN
  logic [NUM_WIRES-1:0] log_mem [NUM_VEC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VEC; i++) log_mem[i] <= '0;
    end else if (run_start) begin
      for (int i = 0; i < NUM_VEC; i++) log_mem[i] <= '0;
    end else if (state == ST_CHECK) begin
      log_mem[v] <= syndrome;
    end
  end

  assign log_data = log_mem[log_idx];
`else
  logic unused_syndrome;
  assign unused_syndrome = ^syndrome;
`endif

endmodule

// File: tb/tb_mux_diag_sequencer.sv
// Directed bench: behavioural mux with injectable faults drives taps; immediate assertions check results.
module tb_mux_diag_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] taps;
  logic       I0, I1, S;
  logic       busy, done;
  logic [8:0] cand;
  logic [3:0] err_cnt;
  logic       fault_found;
`ifdef MUX_DIAG_SYNDROME_LOG_EN
  logic [2:0] log_idx;
  logic [8:0] log_data;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0 clean, 1 w0 sa1, 2 w5 sa0 propagating, 3 w8 sa0

  mux_diag_sequencer #(.SETTLE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .taps        (taps),
    .I0          (I0),
    .I1          (I1),
    .S           (S),
    .busy        (busy),
    .done        (done),
    .cand        (cand),
    .err_cnt     (err_cnt),
    .fault_found (fault_found)
`ifdef MUX_DIAG_SYNDROME_LOG_EN
    ,
    .log_idx     (log_idx),
    .log_data    (log_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2:1 mux wire model with fault injection.
  always_comb begin
    taps    = '0;
    taps[0] = I0;
    taps[1] = I1;
    taps[2] = S;
    taps[3] = S;
    taps[4] = S;
    taps[5] = ~S;
    taps[6] = I1 & S;
    taps[7] = I0 & ~S;
    case (mode)
      1: taps[0] = 1'b1;
      2: begin
        taps[5] = 1'b0;
        taps[7] = I0 & taps[5];
      end
      default: ;
    endcase
    taps[8] = taps[6] | taps[7];
    if (mode == 3) taps[8] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full run from an already-issued start: checks done timing at edge 48.
  task automatic finish_run(input string tag, input logic [8:0] exp_cand, input logic [3:0] exp_err);
    repeat (47) @(posedge clk);
    #1;
    chk({tag, "_done47"}, done, 1'b0);
    chk({tag, "_busy47"}, busy, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_done48"}, done, 1'b1);
    chk({tag, "_busy48"}, busy, 1'b0);
    chk({tag, "_cand"}, cand, exp_cand);
    chk({tag, "_err"}, err_cnt, exp_err);
    chk({tag, "_ff"}, fault_found, exp_err != 4'd0);
    chk({tag, "_vec_hold"}, {I0, I1, S}, 3'b111);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
`ifdef MUX_DIAG_SYNDROME_LOG_EN
    log_idx = 3'd0;
`endif
    #12;
    chk("rst_vec", {I0, I1, S}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cand", cand, 9'h1FF);
    chk("rst_err", err_cnt, 4'd0);
    chk("rst_ff", fault_found, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    mode = 0;
    pulse_start();
    chk("clean_busy0", busy, 1'b1);
    finish_run("clean", 9'h1FF, 4'd0);

    mode = 1;
    pulse_start();
    finish_run("w0sa1", 9'h001, 4'd4);
`ifdef MUX_DIAG_SYNDROME_LOG_EN
    log_idx = 3'd1;
    #1 chk("log1", log_data, 9'h001);
    log_idx = 3'd4;
    #1 chk("log4", log_data, 9'h000);
`endif

    // Restart from DONE clears results immediately.
    pulse_start();
    chk("rerun_done", done, 1'b0);
    chk("rerun_busy", busy, 1'b1);
    chk("rerun_cand", cand, 9'h1FF);
    chk("rerun_err", err_cnt, 4'd0);
    mode = 2;
    finish_run("w5sa0", 9'h034, 4'd4);

    // start while busy must not disturb timing.
    mode = 3;
    pulse_start();
    repeat (10) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    chk("w8_done47", done, 1'b0);
    @(posedge clk);
    #1;
    chk("w8_done48", done, 1'b1);
    chk("w8_cand", cand, 9'h1FF);
    chk("w8_err", err_cnt, 4'd4);

    // Reset during WAIT of vector 3.
    mode = 1;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    chk("mid_vec", {I0, I1, S}, 3'b011);
    chk("mid_err", err_cnt, 4'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", {I0, I1, S}, 3'b000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cand", cand, 9'h1FF);
    chk("arst_err", err_cnt, 4'd0);
    chk("arst_ff", fault_found, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("noresume_busy", busy, 1'b0);
    chk("noresume_done", done, 1'b0);
    pulse_start();
    finish_run("post_rst", 9'h001, 4'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
